// File: rtl/svo_frame_align.sv
// Pixel-stream frame aligner: forwards only whole, SOF-aligned frames of H*V pixels,
// resyncing on early/late SOF and optionally padding mid-frame underruns.
module svo_frame_align #(
  parameter int SVO_HOR_PIXELS = 640,
  parameter int SVO_VER_PIXELS = 480,
  parameter int SVO_BITS_PER_PIXEL = 24,
  parameter int FILL_UNDERRUN = 1,
  parameter logic [SVO_BITS_PER_PIXEL-1:0] FILL_COLOR = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_axis_tvalid,
  output logic                          in_axis_tready,
  input  logic [SVO_BITS_PER_PIXEL-1:0] in_axis_tdata,
  input  logic                          in_axis_tuser,
  output logic                          out_axis_tvalid,
  input  logic                          out_axis_tready,
  output logic [SVO_BITS_PER_PIXEL-1:0] out_axis_tdata,
  output logic                          out_axis_tuser,
  output logic                          locked,
  output logic                          err_pulse,
  output logic [7:0]                    cnt_early,
  output logic [7:0]                    cnt_late,
  output logic [15:0]                   cnt_fill
);
  localparam int NUM_PIXELS = SVO_HOR_PIXELS * SVO_VER_PIXELS;
  localparam int PW = $clog2(NUM_PIXELS) + 1;
  localparam logic [PW-1:0] LAST_POS = PW'(NUM_PIXELS - 1);
  // In a 1x1 frame the pixel after an SOF is again frame position 0.
  localparam logic [PW-1:0] SOF_NEXT = (NUM_PIXELS == 1) ? '0 : PW'(1);

  typedef enum logic {SEARCH = 1'b0, RUN = 1'b1} state_t;

  state_t                        state, state_next;
  logic [PW-1:0]                 pos, pos_next, pos_inc;
  logic                          slot, xfer, load, load_user;
  logic                          err_next, inc_early, inc_late, inc_fill;
  logic [SVO_BITS_PER_PIXEL-1:0] load_data;

  // Valid/ready: a beat moves when valid && ready are both high at a rising clk edge;
  // valid never depends on ready and the output beat is held stable until taken.
  assign slot    = !out_axis_tvalid || out_axis_tready;
  assign pos_inc = (pos == LAST_POS) ? '0 : pos + PW'(1);
  assign xfer    = in_axis_tvalid && in_axis_tready;
  assign locked  = (state == RUN);

  // A non-SOF beat at frame start is always dropped, so it needs no output slot.
  always_comb begin
    in_axis_tready = slot;
    if (state == SEARCH) begin
      in_axis_tready = !in_axis_tuser || slot;
    end else if (pos == '0 && !in_axis_tuser) begin
      in_axis_tready = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    pos_next   = pos;
    load       = 1'b0;
    load_user  = 1'b0;
    load_data  = in_axis_tdata;
    err_next   = 1'b0;
    inc_early  = 1'b0;
    inc_late   = 1'b0;
    inc_fill   = 1'b0;
    case (state)
      SEARCH: begin
        if (xfer && in_axis_tuser) begin
          load       = 1'b1;
          load_user  = 1'b1;
          pos_next   = SOF_NEXT;
          state_next = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          if (in_axis_tuser) begin
            load      = 1'b1;
            load_user = 1'b1;
            pos_next  = SOF_NEXT;
            if (pos != '0) begin
              err_next  = 1'b1;
              inc_early = 1'b1;
            end
          end else if (pos != '0) begin
            load     = 1'b1;
            pos_next = pos_inc;
          end else begin
            state_next = SEARCH;
            err_next   = 1'b1;
            inc_late   = 1'b1;
          end
        end else if (FILL_UNDERRUN != 0 && !in_axis_tvalid && slot && pos != '0) begin
          load      = 1'b1;
          load_data = FILL_COLOR;
          pos_next  = pos_inc;
          inc_fill  = 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= SEARCH;
      pos             <= '0;
      out_axis_tvalid <= 1'b0;
      out_axis_tdata  <= '0;
      out_axis_tuser  <= 1'b0;
      err_pulse       <= 1'b0;
      cnt_early       <= '0;
      cnt_late        <= '0;
      cnt_fill        <= '0;
    end else begin
      state     <= state_next;
      pos       <= pos_next;
      err_pulse <= err_next;
      if (load) begin
        out_axis_tvalid <= 1'b1;
        out_axis_tdata  <= load_data;
        out_axis_tuser  <= load_user;
      end else if (slot) begin
        out_axis_tvalid <= 1'b0;
      end
      if (inc_early && cnt_early != 8'hFF) cnt_early <= cnt_early + 8'd1;
      if (inc_late && cnt_late != 8'hFF) cnt_late <= cnt_late + 8'd1;
      if (inc_fill && cnt_fill != 16'hFFFF) cnt_fill <= cnt_fill + 16'd1;
    end
  end
endmodule

// File: doc/svo_frame_align.md
Name: svo_frame_align

Overview:
- Pixel-stream conditioning stage placed directly downstream of the video DMA's output stream, in the oclk domain, ahead of the timing encoder.
- Guarantees the encoder sees whole, SOF-aligned frames of exactly SVO_HOR_PIXELS*SVO_VER_PIXELS pixels.
- Resynchronises on missing, early or late start-of-frame markers and optionally pads mid-frame underruns with a fill colour.
- Reports lock state and error counters.

Parameters:
SVO_HOR_PIXELS, 640, active pixels per line
SVO_VER_PIXELS, 480, active lines per frame
SVO_BITS_PER_PIXEL, 24, pixel width
FILL_UNDERRUN, 1, 1 = emit FILL_COLOR when input starves mid-frame; 0 = stall
FILL_COLOR, 0, pixel value used for padding (SVO_BITS_PER_PIXEL wide)

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
in_axis_tvalid  in  1  input pixel valid
in_axis_tready  out  1  input pixel accept
in_axis_tdata  in  SVO_BITS_PER_PIXEL  input pixel
in_axis_tuser  in  1  input start of frame
out_axis_tvalid  out  1  output pixel valid
out_axis_tready  in  1  output accept
out_axis_tdata  out  SVO_BITS_PER_PIXEL  output pixel
out_axis_tuser  out  1  output start of frame
locked  out  1  high while in RUN
err_pulse  out  1  one-cycle pulse on any early/late SOF event
cnt_early  out  8  early-SOF events, saturating
cnt_late  out  8  late/missing-SOF events, saturating
cnt_fill  out  16  padded pixels, saturating

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). All state flops are cleared asynchronously on reset.
- Reset values: state=SEARCH, pos=0, out_axis_tvalid=0, out_axis_tdata=0, out_axis_tuser=0, locked=0, err_pulse=0, all counters=0.
- pos: frame position counter, clog2(NUM_PIXELS)+1 bits, NUM_PIXELS=H*V. It counts pixels already loaded for the current frame and wraps from NUM_PIXELS-1 to 0.
- Output register: single stage.
  - slot = !out_axis_tvalid || out_axis_tready.
  - Loading the register sets tvalid=1.
  - If slot is true and nothing is loaded, tvalid goes to 0.
  - Latency from input acceptance to out_axis_tvalid is 1 cycle.
  - Sustained throughput is 1 pixel/clk.
- in_axis_tready is combinational:
  - SEARCH: (!in_axis_tuser || slot).
  - RUN: slot, except that an input with tuser=0 at pos==0 is accepted unconditionally.
- SEARCH state:
  - Accepted non-SOF pixels are discarded.
  - An accepted SOF pixel is loaded with tuser=1, sets pos=1 and moves the state to RUN.
- RUN state, when an input transfer occurs:
  - tuser=1, pos==0: load with tuser=1; pos=1.
  - tuser=0, pos!=0: load with tuser=0; pos=pos+1, wrapping to 0 at NUM_PIXELS.
  - tuser=1, pos!=0 (early SOF): load with tuser=1; pos=1; err_pulse; cnt_early++.
  - tuser=0, pos==0 (late/missing SOF): drop the pixel; state=SEARCH; err_pulse; cnt_late++.
- RUN state, underrun: applies when in_axis_tvalid=0, slot=1, pos!=0 and FILL_UNDERRUN=1.
  - Load FILL_COLOR with tuser=0; pos++; cnt_fill++.
  - No padding at pos==0: the block waits for the real SOF.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-frame:
  - Output is dropped immediately (tvalid=0).
  - After release the block re-enters SEARCH, and the next output is an SOF.
- A 1x1 frame (H=V=1) is legal: every pixel has pos==0 and must carry SOF.

Test Plan:
- Clean 4x2 frames (H=4, V=2), out_axis_tready=1, two back-to-back frames → 16 outputs; tuser=1 exactly at outputs 0 and 8; locked=1 from cycle after first SOF; all counters 0.
- Stream starts with 3 non-SOF pixels then a proper frame → first 3 dropped (tready=1); first output is the SOF pixel; cnt_late=0.
- SOF arrives after 5 pixels of an 8-pixel frame → 5 pixels out, then the new SOF out with tuser=1; cnt_early=1; err_pulse high 1 cycle; the following frame is complete.
- Frame with 9 pixels (extra non-SOF at pos 0) → extra pixel dropped; cnt_late=1; locked falls; next SOF relocks.
- FILL_UNDERRUN=1, input stalls 3 cycles after pixel 2 of a frame, out_axis_tready=1 → 3 outputs of FILL_COLOR; cnt_fill=3; frame still totals 8 outputs. With FILL_UNDERRUN=0 → out_axis_tvalid=0 for the stall and cnt_fill stays 0.
- Backpressure: out_axis_tready toggled 1/0 every cycle → no pixel lost or duplicated, tdata stable while tvalid && !tready; reset pulse mid-frame → tvalid=0 at once, next output after release has tuser=1.
